// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous FIFO write port
// between NUM_REQ requesters, with bursts of up to BURST_LEN beats per grant.
//
// Ports:
//   clk_i              FIFO clock, all logic on the rising edge
//   a_rst_n_i          asynchronous active-low reset
//   req_valid_i        per-requester write request
//   req_data_i         packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o        per-requester accept (combinational)
//   fifo_full_i        FIFO full flag
//   fifo_almost_full_i FIFO almost-full flag (used only with throttling)
//   fifo_wr_en_o       FIFO write strobe (combinational)
//   fifo_data_o        FIFO write data (combinational)
//   grant_o            one-hot registered grant, zero in IDLE
//   grant_id_o         registered grant index, zero in IDLE
//
// Build option: define FIFO_WR_ARB_AF_THROTTLE_EN to hold off new grants in
// IDLE while fifo_almost_full_i is high.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                            clk_i,
  input  logic                            a_rst_n_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic                            fifo_full_i,
  input  logic                            fifo_almost_full_i,
  output logic                            fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]           fifo_data_o,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id_o
);

  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [NUM_REQ-1:0]    r_grant;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_pick;
  logic [ID_WIDTH:0]     w_sum;
  logic                  w_arb_en;
  logic                  w_in_burst;
  logic                  w_gvalid;
  logic                  w_beat;
  logic                  w_last_beat;
  logic [ID_WIDTH-1:0]   w_next_ptr;
  logic [DATA_WIDTH-1:0] w_data;

`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
  assign w_arb_en = ~fifo_almost_full_i;
`else
  logic w_unused_af;
  assign w_unused_af = fifo_almost_full_i;
  assign w_arb_en    = 1'b1;
`endif

  // First valid requester searching upward from r_rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(i);
      if (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!w_found && req_valid_i[ID_WIDTH'(w_sum)]) begin
        w_found = 1'b1;
        w_pick  = ID_WIDTH'(w_sum);
      end
    end
  end

  // Granted requester's data, selected by the one-hot grant
  always_comb begin
    w_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_in_burst  = (r_state == BURST);
  assign w_gvalid    = |(req_valid_i & r_grant);
  assign w_beat      = w_in_burst & w_gvalid & ~fifo_full_i;
  assign w_last_beat = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
  assign w_next_ptr  = (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : r_grant_id + ID_WIDTH'(1);

  // Write side follows registered state so reset clears it asynchronously
  assign fifo_wr_en_o = w_beat;
  assign fifo_data_o  = w_in_burst ? w_data : '0;
  assign req_ready_o  = (w_in_burst && !fifo_full_i) ? r_grant : '0;
  assign grant_o      = r_grant;
  assign grant_id_o   = r_grant_id;

  // Arbitration FSM: IDLE picks a grant, BURST streams until last beat or valid drop
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_grant_id <= '0;
      r_grant    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_en && w_found) begin
            r_state    <= BURST;
            r_grant_id <= w_pick;
            r_grant    <= NUM_REQ'(1) << w_pick;
            r_beat_cnt <= '0;
          end
        end
        BURST: begin
          if ((w_beat && w_last_beat) || !w_gvalid) begin
            // Release: the bubble cycle in IDLE re-arbitrates from the next index
            r_state    <= IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_grant_id <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_af;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data;
  logic [NR-1:0]     grant;
  logic [1:0]        grant_id;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
    .clk_i              (clk),
    .a_rst_n_i          (rst_n),
    .req_valid_i        (req_valid),
    .req_data_i         (req_data),
    .req_ready_o        (req_ready),
    .fifo_full_i        (fifo_full),
    .fifo_almost_full_i (fifo_af),
    .fifo_wr_en_o       (fifo_wr_en),
    .fifo_data_o        (fifo_data),
    .grant_o            (grant),
    .grant_id_o         (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  int rem[NR];
  int seq[NR];
  bit mon_en = 1'b0;
  int cyc = 0;
  int w_first = -1;
  int w_last  = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] tag(input int k, input int s);
    return {16'(k), 16'(s)};
  endfunction

  task automatic expw(input int k, input int s);
    exp_q.push_back(tag(k, s));
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid[k] = (rem[k] > 0);
      req_data[k*DW +: DW] = tag(k, seq[k]);
    end
  endtask

  task automatic load(input int k, input int n);
    rem[k] = n;
    seq[k] = 0;
  endtask

  // One clock: capture handshakes before the edge, advance requesters after it
  task automatic cycle();
    logic [NR-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (hs[k]) begin
        seq[k]++;
        rem[k]--;
      end
    end
    drive();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle();
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    cycle();
    cycle();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every FIFO write is checked against the scoreboard queue
  always @(negedge clk) begin
    if (mon_en && fifo_wr_en) begin
      logic [DW-1:0] e;
      chk("no_write_while_full", 64'(fifo_full), 64'd0);
      if (w_first < 0) w_first = cyc;
      w_last = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(fifo_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", 64'(fifo_data), 64'(e));
        chk("wr_grant", 64'(grant), 64'(NR'(1) << e[17:16]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    fifo_full = 1'b0;
    fifo_af = 1'b0;
    for (int k = 0; k < NR; k++) load(k, 100);
    drive();

    // Reset state with all requesters valid
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_data", 64'(fifo_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_grant", 64'(grant), 64'b0001);
    chk("first_grant_id", 64'(grant_id), 64'd0);
    @(posedge clk); #3;
    chk("pre_rst_wr_en", 64'(fifo_wr_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    chk("async_rst_grant", 64'(grant), 64'd0);
    chk("async_rst_data", 64'(fifo_data), 64'd0);
    for (int k = 0; k < NR; k++) load(k, 0);
    drive();
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Round robin: 0,1,2,3,0 with 4 beats each
    load(0, 8); load(1, 4); load(2, 4); load(3, 4);
    for (int s = 0; s < 4; s++) expw(0, s);
    for (int s = 0; s < 4; s++) expw(1, s);
    for (int s = 0; s < 4; s++) expw(2, s);
    for (int s = 0; s < 4; s++) expw(3, s);
    for (int s = 4; s < 8; s++) expw(0, s);
    w_first = -1;
    drive();
    drain("rr");
    chk("rr_span", 64'(w_last - w_first + 1), 64'd24);

    // Early release by requester 2, then rr_ptr=3 favours 3 over 0
    load(2, 2);
    expw(2, 0); expw(2, 1);
    drive();
    drain("early");
    load(0, 1); load(3, 1);
    expw(3, 0); expw(0, 0);
    drive();
    drain("rr_ptr3");

    // Full stall for 3 cycles at beat_cnt=1
    load(1, 4);
    for (int s = 0; s < 4; s++) expw(1, s);
    drive();
    cycle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      fifo_full = 1'b1;
      #1;
      chk("stall_wr_en", 64'(fifo_wr_en), 64'd0);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_grant", 64'(grant), 64'b0010);
      cycle();
    end
    fifo_full = 1'b0;
    drain("stall");

    // Almost-full throttling of new grants
    load(1, 1);
    expw(1, 0);
    fifo_af = 1'b1;
    drive();
`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("af_hold_grant", 64'(grant), 64'd0);
    end
    fifo_af = 1'b0;
    cycle();
    chk("af_release_grant", 64'(grant), 64'b0010);
`else
    cycle();
    chk("af_ignored_grant", 64'(grant), 64'b0010);
    fifo_af = 1'b0;
`endif
    drain("af");

    // Tagged traffic from all requesters under random full
    load(0, 6); load(1, 2); load(2, 5); load(3, 4);
    for (int s = 0; s < 4; s++) expw(2, s);
    for (int s = 0; s < 4; s++) expw(3, s);
    for (int s = 0; s < 4; s++) expw(0, s);
    expw(1, 0); expw(1, 1);
    expw(2, 4);
    expw(0, 4); expw(0, 5);
    drive();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      cycle();
    end
    fifo_full = 1'b0;
    drain("integrity");
    for (int k = 0; k < NR; k++) chk("integrity_rem", 64'(rem[k]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of a synchronous FIFO between NUM_REQ requesters.
- Grants one requester at a time for a burst of up to BURST_LEN beats.
- Drives the FIFO write strobe and data.
- Back-pressures requesters from the FIFO full flag.
- Sits between producer blocks and the FIFO write side, on the FIFO clock.

Parameters:
NUM_REQ, 4, number of requesters (>= 2).
DATA_WIDTH, 32, FIFO data width (>= 1).
BURST_LEN, 4, maximum beats per grant (>= 1).
ID_WIDTH, $clog2(NUM_REQ), width of grant_id_o (derived localparam, not overridable).

Ports:
clk_i  input  1  FIFO clock, all logic rising-edge.
a_rst_n_i  input  1  reset, asynchronous, active-low.
req_valid_i  input  NUM_REQ  per-requester write request.
req_data_i  input  NUM_REQ*DATA_WIDTH  packed data; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
req_ready_o  output  NUM_REQ  per-requester beat accepted this cycle when valid & ready.
fifo_full_i  input  1  FIFO full flag.
fifo_almost_full_i  input  1  FIFO almost-full flag.
fifo_wr_en_o  output  1  FIFO write strobe.
fifo_data_o  output  DATA_WIDTH  FIFO write data.
grant_o  output  NUM_REQ  one-hot current grant; all zero in IDLE.
grant_id_o  output  ID_WIDTH  index of the current grant; 0 in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
  - All outputs 0: req_ready_o, fifo_wr_en_o, fifo_data_o, grant_o, grant_id_o.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid_i is high, choose the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register it as the grant; beat_cnt=0; go to BURST.
  - No writes occur in IDLE; arbitration latency is 1 cycle.
- BURST, granted index g:
  - beat = req_valid_i[g] & ~fifo_full_i.
  - fifo_wr_en_o = beat; fifo_data_o = req_data_i[g].
  - req_ready_o[g] = ~fifo_full_i; every other ready bit is 0.
  - On beat: beat_cnt++.
- BURST exit, go to IDLE with rr_ptr = (g+1) mod NUM_REQ when either:
  - beat occurs with beat_cnt == BURST_LEN-1; or
  - req_valid_i[g] == 0 in BURST (no beat that cycle).
- Grant change: one bubble cycle (IDLE) between consecutive grants, including a re-grant of the same requester.
- fifo_full_i high in BURST:
  - No beat, grant held, beat_cnt held, no timeout.
- Requester handshake:
  - Data is held stable while valid & ~ready.
  - Dropping valid is legal and releases the grant.
- Combinational outputs: fifo_wr_en_o, req_ready_o and fifo_data_o are combinational from registered state plus inputs. Never write when fifo_full_i=1.
- Non-granted requests: never lost; they wait, and are served in round-robin order.
- Reset mid-burst: burst aborted immediately; a beat in flight that cycle is not written.
- BURST_LEN=1: every beat releases the grant.

Optional Feature:
FIFO_WR_ARB_AF_THROTTLE_EN
- Defined: in IDLE, no new grant is issued while fifo_almost_full_i=1; a burst already in BURST continues to completion (still gated by full).
- Undefined: fifo_almost_full_i is ignored; the port remains present and unused.

Test Plan:
- Reset: assert a_rst_n_i mid-cycle with req_valid_i=4'b1111 -> all outputs 0 immediately (asynchronously); after release, first grant is requester 0, one cycle later.
- Round-robin: all four requesters valid continuously, BURST_LEN=4 -> grants 0,1,2,3,0, each writing 4 beats with one idle cycle between; 20 writes in 24 cycles after first grant.
- Early release: requester 2 alone, valid for 2 beats then low -> 2 FIFO writes, grant released, rr_ptr=3.
- Full stall: fifo_full_i=1 for 3 cycles mid-burst at beat_cnt=1 -> fifo_wr_en_o=0 and ready=0 for 3 cycles, grant held, burst finishes with 4 total beats and the data order intact.
- Throttle: with FIFO_WR_ARB_AF_THROTTLE_EN, fifo_almost_full_i=1 in IDLE and requester 1 valid -> no grant until almost_full drops, then grant 1 next cycle; without the macro -> grant 1 immediately.
- Data integrity: requesters send tagged sequences {id,seq} under random full -> FIFO content matches per-requester order, no duplication or loss, and no write while full.
